// File: rtl/huffman_ac_encoder.sv
// JPEG AC entropy-coding front end: run/size symbol formation, ZRL/EOB insertion
// and Huffman lookup from runtime-loadable code tables, one record per output slot.
module huffman_ac_encoder #(
    parameter int COEFF_WIDTH  = 11,
    parameter int BLOCK_LEN    = 63,
    parameter int MAX_CODE_LEN = 16,
    parameter int NUM_TABLES   = 2,
    parameter int SIZE_W       = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [COEFF_WIDTH-1:0]   coeff_in,
    input  logic                            coeff_valid_in,
    output logic                            coeff_ready_out,
    input  logic [$clog2(NUM_TABLES)-1:0]   table_sel_in,
    input  logic                            tbl_wr_en_in,
    input  logic [$clog2(NUM_TABLES)-1:0]   tbl_wr_sel_in,
    input  logic [7:0]                      tbl_wr_addr_in,
    input  logic [MAX_CODE_LEN-1:0]         tbl_wr_code_in,
    input  logic [4:0]                      tbl_wr_len_in,
    output logic                            sym_valid_out,
    input  logic                            sym_ready_in,
    output logic [MAX_CODE_LEN-1:0]         huff_code_out,
    output logic [4:0]                      huff_len_out,
    output logic [COEFF_WIDTH-2:0]          amp_out,
    output logic [SIZE_W-1:0]               amp_len_out,
    output logic                            eob_out,
    output logic                            err_out
);
    localparam int TSW   = $clog2(NUM_TABLES);
    localparam int AMP_W = COEFF_WIDTH - 1;
    localparam int IDX_W = $clog2(BLOCK_LEN + 1);
    localparam logic [COEFF_WIDTH-1:0] MOST_NEG  = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
    localparam logic [COEFF_WIDTH-1:0] CLAMP_NEG = MOST_NEG | COEFF_WIDTH'(1);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {COLLECT, EMIT_ZRL, EMIT_SYM} state_t;

    logic [MAX_CODE_LEN-1:0] code_mem [NUM_TABLES][256];
    logic [4:0]              len_mem  [NUM_TABLES][256];

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        run_q, run_d, idx_q, idx_d;
    logic [TSW-1:0]          tsel_q, tsel_d;
    logic [SIZE_W-1:0]       pend_size_q, pend_size_d;
    logic [AMP_W-1:0]        pend_amp_q, pend_amp_d;
    logic                    pend_last_q, pend_last_d;
    logic                    sym_valid_q, sym_valid_d;
    logic [MAX_CODE_LEN-1:0] code_q, code_d;
    logic [4:0]              len_q, len_d;
    logic [AMP_W-1:0]        amp_q, amp_d;
    logic [SIZE_W-1:0]       amp_len_q, amp_len_d;
    logic                    eob_q, eob_d;
    logic                    err_q, err_d;

    logic                    slot_free, coeff_ready, accept, is_last, coeff_zero;
    logic                    clamp_err;
    logic [COEFF_WIDTH-1:0]  coeff_c, mag, amp_full;
    logic [SIZE_W-1:0]       coeff_size;
    logic [AMP_W-1:0]        amp_mask, coeff_amp;
    logic                    load, ld_eob;
    logic [7:0]              ld_sym;
    logic [AMP_W-1:0]        ld_amp;
    logic [SIZE_W-1:0]       ld_amp_len;
    logic [TSW-1:0]          ld_tsel;
    logic [MAX_CODE_LEN-1:0] lut_code;
    logic [4:0]              lut_len;

    assign slot_free   = !sym_valid_q || sym_ready_in;
    assign coeff_ready = (state_q == COLLECT) && slot_free && !rst_in;
    assign accept      = coeff_valid_in && coeff_ready;
    assign is_last     = (idx_q == LAST_IDX);
    assign coeff_zero  = (coeff_in == '0);

    // The most negative code has no positive twin, so it folds onto -(2^(W-1)-1).
    always_comb begin
        clamp_err  = (coeff_in == MOST_NEG);
        coeff_c    = clamp_err ? CLAMP_NEG : coeff_in;
        mag        = coeff_c[COEFF_WIDTH-1] ? (COEFF_WIDTH'(0) - coeff_c) : coeff_c;
        coeff_size = '0;
        for (int i = 0; i < COEFF_WIDTH; i++) begin
            if (mag[i]) coeff_size = SIZE_W'(i + 1);
        end
        amp_full  = coeff_c[COEFF_WIDTH-1] ? (coeff_c - COEFF_WIDTH'(1)) : coeff_c;
        amp_mask  = (AMP_W'(1) << coeff_size) - AMP_W'(1);
        coeff_amp = amp_full[AMP_W-1:0] & amp_mask;
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        idx_d       = idx_q;
        tsel_d      = tsel_q;
        pend_size_d = pend_size_q;
        pend_amp_d  = pend_amp_q;
        pend_last_d = pend_last_q;
        sym_valid_d = sym_valid_q;
        code_d      = code_q;
        len_d       = len_q;
        amp_d       = amp_q;
        amp_len_d   = amp_len_q;
        eob_d       = eob_q;
        err_d       = err_q;
        load        = 1'b0;
        ld_sym      = 8'h00;
        ld_amp      = '0;
        ld_amp_len  = '0;
        ld_eob      = 1'b0;
        ld_tsel     = tsel_q;

        if (sym_valid_q && sym_ready_in) sym_valid_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    // Index 0 picks the table for this block; the lookup uses it immediately.
                    if (idx_q == '0) begin
                        tsel_d  = table_sel_in;
                        ld_tsel = table_sel_in;
                    end
                    idx_d = is_last ? '0 : idx_q + IDX_W'(1);
                    if (coeff_zero) begin
                        if (is_last) begin
                            load   = 1'b1;
                            ld_eob = 1'b1;
                            run_d  = '0;
                        end else begin
                            run_d = run_q + IDX_W'(1);
                        end
                    end else begin
                        if (clamp_err) err_d = 1'b1;
                        if (run_q < IDX_W'(16)) begin
                            load       = 1'b1;
                            ld_sym     = {run_q[3:0], coeff_size[3:0]};
                            ld_amp     = coeff_amp;
                            ld_amp_len = coeff_size;
                            ld_eob     = is_last;
                            run_d      = '0;
                        end else begin
                            pend_size_d = coeff_size;
                            pend_amp_d  = coeff_amp;
                            pend_last_d = is_last;
                            state_d     = EMIT_ZRL;
                        end
                    end
                end
            end
            EMIT_ZRL: begin
                if (slot_free) begin
                    load   = 1'b1;
                    ld_sym = 8'hF0;
                    run_d  = run_q - IDX_W'(16);
                    if (run_q < IDX_W'(32)) state_d = EMIT_SYM;
                end
            end
            EMIT_SYM: begin
                if (slot_free) begin
                    load       = 1'b1;
                    ld_sym     = {run_q[3:0], pend_size_q[3:0]};
                    ld_amp     = pend_amp_q;
                    ld_amp_len = pend_size_q;
                    ld_eob     = pend_last_q;
                    run_d      = '0;
                    state_d    = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        lut_code = code_mem[ld_tsel][ld_sym];
        lut_len  = len_mem[ld_tsel][ld_sym];

        if (load) begin
            sym_valid_d = 1'b1;
            code_d      = lut_code;
            len_d       = lut_len;
            amp_d       = ld_amp;
            amp_len_d   = ld_amp_len;
            eob_d       = ld_eob;
            if (lut_len == 5'd0) err_d = 1'b1;
        end
    end

    // Table storage deliberately has no reset so loaded tables survive a pipeline flush.
    always_ff @(posedge clk_in) begin
        if (tbl_wr_en_in) begin
            code_mem[tbl_wr_sel_in][tbl_wr_addr_in] <= tbl_wr_code_in;
            len_mem[tbl_wr_sel_in][tbl_wr_addr_in]  <= tbl_wr_len_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= COLLECT;
            run_q       <= '0;
            idx_q       <= '0;
            tsel_q      <= '0;
            pend_size_q <= '0;
            pend_amp_q  <= '0;
            pend_last_q <= 1'b0;
            sym_valid_q <= 1'b0;
            code_q      <= '0;
            len_q       <= '0;
            amp_q       <= '0;
            amp_len_q   <= '0;
            eob_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            idx_q       <= idx_d;
            tsel_q      <= tsel_d;
            pend_size_q <= pend_size_d;
            pend_amp_q  <= pend_amp_d;
            pend_last_q <= pend_last_d;
            sym_valid_q <= sym_valid_d;
            code_q      <= code_d;
            len_q       <= len_d;
            amp_q       <= amp_d;
            amp_len_q   <= amp_len_d;
            eob_q       <= eob_d;
            err_q       <= err_d;
        end
    end

    assign coeff_ready_out = coeff_ready;
    assign sym_valid_out   = sym_valid_q;
    assign huff_code_out   = code_q;
    assign huff_len_out    = len_q;
    assign amp_out         = amp_q;
    assign amp_len_out     = amp_len_q;
    assign eob_out         = eob_q;
    assign err_out         = err_q;
endmodule

// File: tb/tb_huffman_ac_encoder.sv
// Testbench for huffman_ac_encoder: block-level run/size model feeding an
// expected-record queue that a negedge monitor drains as records transfer.
module tb_huffman_ac_encoder;
    localparam int CW  = 11;
    localparam int BL  = 63;
    localparam int MCL = 16;
    localparam int NT  = 2;
    localparam int SW  = 4;

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
        logic [9:0]  amp;
        logic [3:0]  amp_len;
        logic        eob;
    } rec_t;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [CW-1:0]     coeff_in;
    logic              coeff_valid_in;
    logic              coeff_ready_out;
    logic [0:0]        table_sel_in;
    logic              tbl_wr_en_in;
    logic [0:0]        tbl_wr_sel_in;
    logic [7:0]        tbl_wr_addr_in;
    logic [MCL-1:0]    tbl_wr_code_in;
    logic [4:0]        tbl_wr_len_in;
    logic              sym_valid_out;
    logic              sym_ready_in;
    logic [MCL-1:0]    huff_code_out;
    logic [4:0]        huff_len_out;
    logic [CW-2:0]     amp_out;
    logic [SW-1:0]     amp_len_out;
    logic              eob_out;
    logic              err_out;

    rec_t              dut_rec;
    rec_t              exp_q[$];
    logic [15:0]       ref_code [2][256];
    logic [4:0]        ref_len  [2][256];
    int                checks = 0;
    int                errors = 0;
    int                rec_count = 0;

    always #5 clk_in = ~clk_in;

    huffman_ac_encoder #(
        .COEFF_WIDTH(CW), .BLOCK_LEN(BL), .MAX_CODE_LEN(MCL), .NUM_TABLES(NT), .SIZE_W(SW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .coeff_in(coeff_in), .coeff_valid_in(coeff_valid_in), .coeff_ready_out(coeff_ready_out),
        .table_sel_in(table_sel_in),
        .tbl_wr_en_in(tbl_wr_en_in), .tbl_wr_sel_in(tbl_wr_sel_in), .tbl_wr_addr_in(tbl_wr_addr_in),
        .tbl_wr_code_in(tbl_wr_code_in), .tbl_wr_len_in(tbl_wr_len_in),
        .sym_valid_out(sym_valid_out), .sym_ready_in(sym_ready_in),
        .huff_code_out(huff_code_out), .huff_len_out(huff_len_out),
        .amp_out(amp_out), .amp_len_out(amp_len_out), .eob_out(eob_out), .err_out(err_out)
    );

    assign dut_rec = {huff_code_out, huff_len_out, amp_out, amp_len_out, eob_out};

    // Every record transfer must match the oldest expected record.
    always @(negedge clk_in) begin
        if (!rst_in && sym_valid_out && sym_ready_in) begin
            rec_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_record: got %h, expected none", dut_rec);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                if (dut_rec !== e) begin
                    errors++;
                    $display("[TB] FAIL record: got code=%h len=%0d amp=%h alen=%0d eob=%b, expected code=%h len=%0d amp=%h alen=%0d eob=%b",
                             dut_rec.code, dut_rec.len, dut_rec.amp, dut_rec.amp_len, dut_rec.eob,
                             e.code, e.len, e.amp, e.amp_len, e.eob);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int size_of(input int v);
        int m;
        int s;
        if (v == -1024) v = -1023;
        m = (v < 0) ? -v : v;
        s = 0;
        while ((m >> s) != 0) s++;
        return s;
    endfunction

    function automatic int amp_of(input int v);
        int s;
        if (v == -1024) v = -1023;
        s = size_of(v);
        return (v > 0) ? v : v + (1 << s) - 1;
    endfunction

    function automatic rec_t make_rec(input int tsel, input logic [7:0] sym, input int amp,
                                      input int amp_len, input logic eob);
        rec_t r;
        r.code    = ref_code[tsel][sym];
        r.len     = ref_len[tsel][sym];
        r.amp     = 10'(amp);
        r.amp_len = 4'(amp_len);
        r.eob     = eob;
        return r;
    endfunction

    task automatic expect_block(input int blk[63], input int tsel);
        int run = 0;
        for (int i = 0; i < 63; i++) begin
            if (blk[i] == 0) begin
                if (i == 62) exp_q.push_back(make_rec(tsel, 8'h00, 0, 0, 1'b1));
                else run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(make_rec(tsel, 8'hF0, 0, 0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(make_rec(tsel, 8'((run << 4) | size_of(blk[i])),
                                         amp_of(blk[i]), size_of(blk[i]), i == 62));
                run = 0;
            end
        end
    endtask

    task automatic write_entry(input int sel, input logic [7:0] addr, input logic [15:0] code,
                               input logic [4:0] len);
        tbl_wr_en_in   = 1'b1;
        tbl_wr_sel_in  = 1'(sel);
        tbl_wr_addr_in = addr;
        tbl_wr_code_in = code;
        tbl_wr_len_in  = len;
        ref_code[sel][addr] = code;
        ref_len[sel][addr]  = len;
        @(posedge clk_in); #1;
        tbl_wr_en_in = 1'b0;
    endtask

    task automatic drive_coeff(input int v, input int tsel);
        int n = 0;
        coeff_valid_in = 1'b1;
        coeff_in       = CW'(v);
        table_sel_in   = 1'(tsel);
        @(negedge clk_in);
        while (!coeff_ready_out && n < 200) begin
            n++;
            @(negedge clk_in);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: coeff_ready_out=%b after %0d cycles, required 1", coeff_ready_out, n);
        end
        @(posedge clk_in); #1;
        coeff_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_in);
            n++;
        end
        #1;
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d records outstanding, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic run_block(input int blk[63], input int tsel);
        expect_block(blk, tsel);
        for (int i = 0; i < 63; i++) drive_coeff(blk[i], tsel);
        wait_drain();
    endtask

    task automatic check_count(input string name, input int start, input int want);
        checks++;
        if (rec_count - start !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d records, required %0d", name, rec_count - start, want);
        end
    endtask

    task automatic check_err(input string name, input logic want);
        checks++;
        if (err_out !== want) begin
            errors++;
            $display("[TB] FAIL %s: err_out=%b, required %b", name, err_out, want);
        end
    endtask

    task automatic test_reset();
        rst_in         = 1'b1;
        coeff_valid_in = 1'b1;
        coeff_in       = CW'(5);
        table_sel_in   = 1'b0;
        sym_ready_in   = 1'b1;
        tbl_wr_en_in   = 1'b0;
        tbl_wr_sel_in  = 1'b0;
        tbl_wr_addr_in = 8'h00;
        tbl_wr_code_in = '0;
        tbl_wr_len_in  = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (coeff_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, required 0", coeff_ready_out);
        end
        @(posedge clk_in); #1;
        rst_in         = 1'b0;
        coeff_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({sym_valid_out, dut_rec, err_out} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b rec=%h err=%b, required all 0", sym_valid_out, dut_rec, err_out);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic load_tables();
        write_entry(0, 8'h00, 16'b1010, 5'd4);
        write_entry(0, 8'h01, 16'b00, 5'd2);
        write_entry(0, 8'h02, 16'b01, 5'd2);
        write_entry(0, 8'h03, 16'b100, 5'd3);
        write_entry(0, 8'h04, 16'b1011, 5'd4);
        write_entry(0, 8'h0A, 16'hFF83, 5'd16);
        write_entry(0, 8'h41, 16'b111011, 5'd6);
        write_entry(0, 8'hE3, 16'hFFED, 5'd16);
        write_entry(0, 8'hF0, 16'b11111111001, 5'd11);
        write_entry(1, 8'h00, 16'b00, 5'd2);
        write_entry(1, 8'h01, 16'b01, 5'd2);
        write_entry(1, 8'h02, 16'b100, 5'd3);
        write_entry(1, 8'h03, 16'b1010, 5'd4);
        write_entry(1, 8'h04, 16'b11000, 5'd5);
        write_entry(1, 8'hF0, 16'b1111111010, 5'd10);
    endtask

    task automatic test_basic();
        int blk[63] = '{default: 0};
        int start = rec_count;
        blk[0] = 5;
        run_block(blk, 0);
        check_count("basic_count", start, 2);
    endtask

    task automatic test_amplitude();
        int blk[63] = '{default: 0};
        blk[0] = -3;
        run_block(blk, 0);
        blk[0] = -1023;
        run_block(blk, 0);
        check_err("err_after_m1023", 1'b0);
        blk[0] = -1024;
        run_block(blk, 0);
        check_err("err_after_clamp", 1'b1);
    endtask

    task automatic test_zrl();
        int blk[63] = '{default: 0};
        int start = rec_count;
        blk[20] = 1;
        expect_block(blk, 0);
        for (int i = 0; i < 63; i++) begin
            drive_coeff(blk[i], 0);
            if (i == 20) begin
                coeff_valid_in = 1'b1;
                coeff_in       = '0;
                @(negedge clk_in);
                checks++;
                if (coeff_ready_out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ready_during_zrl: got %b, required 0", coeff_ready_out);
                end
                @(posedge clk_in); #1;
            end
        end
        wait_drain();
        check_count("zrl_count", start, 3);
    endtask

    task automatic test_long_run();
        int blk[63] = '{default: 0};
        int start = rec_count;
        blk[62] = 7;
        run_block(blk, 0);
        check_count("long_run_count", start, 4);
        blk[62] = 0;
        start = rec_count;
        run_block(blk, 0);
        check_count("all_zero_count", start, 1);
    endtask

    task automatic test_stall();
        int blk[63] = '{default: 0};
        int start = rec_count;
        blk[0] = 5;
        blk[1] = 3;
        expect_block(blk, 0);
        drive_coeff(blk[0], 0);
        sym_ready_in   = 1'b0;
        coeff_valid_in = 1'b1;
        coeff_in       = CW'(blk[1]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            checks++;
            if (coeff_ready_out !== 1'b0 || sym_valid_out !== 1'b1 || exp_q.size() == 0 ||
                dut_rec !== exp_q[0]) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d ready=%b valid=%b rec=%h, required ready=0 valid=1 rec=%h",
                         k, coeff_ready_out, sym_valid_out, dut_rec, (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            @(posedge clk_in); #1;
        end
        sym_ready_in = 1'b1;
        for (int i = 1; i < 63; i++) drive_coeff(blk[i], 0);
        wait_drain();
        check_count("stall_count", start, 3);
    endtask

    task automatic test_back_to_back();
        int blk[63];
        int start = rec_count;
        for (int i = 0; i < 63; i++) blk[i] = (i % 2 != 0) ? -((i % 7) + 1) : (i % 9) + 1;
        expect_block(blk, 0);
        for (int i = 0; i < 63; i++) begin
            coeff_valid_in = 1'b1;
            coeff_in       = CW'(blk[i]);
            table_sel_in   = 1'b0;
            @(negedge clk_in);
            checks++;
            if (coeff_ready_out !== 1'b1 || (i > 0 && sym_valid_out !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL back_to_back: index %0d ready=%b valid=%b, required 1 and 1", i, coeff_ready_out, sym_valid_out);
            end
            @(posedge clk_in); #1;
        end
        coeff_valid_in = 1'b0;
        wait_drain();
        check_count("back_to_back_count", start, 63);
    endtask

    task automatic test_table_select();
        int blk[63] = '{default: 0};
        int start = rec_count;
        blk[0] = 5;
        expect_block(blk, 1);
        drive_coeff(blk[0], 1);
        for (int i = 1; i < 63; i++) drive_coeff(blk[i], 0);
        wait_drain();
        check_count("chroma_count", start, 2);
    endtask

    task automatic test_mid_reset();
        int blk[63] = '{default: 0};
        int vals[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 4};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(make_rec(0, 8'(size_of(vals[i])), amp_of(vals[i]), size_of(vals[i]), 1'b0));
            drive_coeff(vals[i], 0);
        end
        rst_in         = 1'b1;
        coeff_valid_in = 1'b1;
        coeff_in       = CW'(1);
        @(negedge clk_in);
        checks++;
        if (coeff_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_ready: got %b, required 0", coeff_ready_out);
        end
        @(posedge clk_in); #1;
        rst_in         = 1'b0;
        coeff_valid_in = 1'b0;
        exp_q.delete();
        @(negedge clk_in);
        checks++;
        if ({sym_valid_out, dut_rec, err_out} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got valid=%b rec=%h err=%b, required all 0", sym_valid_out, dut_rec, err_out);
        end
        @(posedge clk_in); #1;
        blk[0] = 5;
        run_block(blk, 0);
        check_err("err_after_reset_block", 1'b0);
    endtask

    task automatic test_err_len0();
        int blk[63] = '{default: 0};
        write_entry(1, 8'h01, 16'h0000, 5'd0);
        blk[0] = 1;
        run_block(blk, 1);
        check_err("err_len0", 1'b1);
    endtask

    initial begin
        test_reset();
        load_tables();
        test_basic();
        test_amplitude();
        test_zrl();
        test_long_run();
        test_stall();
        test_back_to_back();
        test_table_select();
        test_mid_reset();
        test_err_len0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_ac_encoder.md
Name: huffman_ac_encoder

Overview:
- Sequential JPEG AC entropy-coding front end for the compression pipeline. Sits between the zigzag/quantiser stage and the bitstream packer.
- Consumes one quantised AC coefficient per handshake, BLOCK_LEN per block. Tracks zero runs and computes size category and amplitude bits.
- Emits ZRL/EOB and (run,size) symbols as right-aligned {code, length, amplitude, amplitude length} records.
- Replaces the fixed combinational code lookup with NUM_TABLES runtime-loadable tables, selectable per block (luma/chroma).

Parameters:
COEFF_WIDTH, 11, signed coefficient width; clamp range ±(2^(COEFF_WIDTH-1)-1)
BLOCK_LEN, 63, AC coefficients per block
MAX_CODE_LEN, 16, maximum Huffman code length
NUM_TABLES, 2, number of loadable code tables
SIZE_W, 4, width of size and amplitude-length fields

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
coeff_in  input  COEFF_WIDTH  signed quantised AC coefficient, zigzag order
coeff_valid_in  input  1  coefficient valid
coeff_ready_out  output  1  encoder accepts coefficient this cycle
table_sel_in  input  $clog2(NUM_TABLES)  table for the block; sampled with coefficient index 0
tbl_wr_en_in  input  1  table write strobe
tbl_wr_sel_in  input  $clog2(NUM_TABLES)  table written
tbl_wr_addr_in  input  8  symbol byte {run[3:0],size[3:0]}
tbl_wr_code_in  input  MAX_CODE_LEN  code, right-aligned
tbl_wr_len_in  input  5  code length; 0 = invalid entry
sym_valid_out  output  1  output record valid
sym_ready_in  input  1  downstream accepts record
huff_code_out  output  MAX_CODE_LEN  Huffman code, right-aligned
huff_len_out  output  5  Huffman code length
amp_out  output  COEFF_WIDTH-1  amplitude bits, right-aligned
amp_len_out  output  SIZE_W  amplitude bit count (0 for ZRL/EOB)
eob_out  output  1  record is EOB, or the last record of its block
err_out  output  1  sticky error flag

Behaviour:
- Reset: all outputs 0, coeff_ready_out 0 in the reset cycle. State ← COLLECT, run counter and index ← 0. Table storage is not reset and holds its contents.
- Handshakes:
  - Input transfer occurs when coeff_valid_in & coeff_ready_out.
  - Output transfer occurs when sym_valid_out & sym_ready_in.
  - While sym_valid_out=1 and transfer has not occurred, all record outputs hold stable.
- Output register: single stage. A new record loads in the same cycle the old one transfers, or when the register is empty. Latency from accepting a coefficient to its record appearing is 1 cycle.
- States:
  - COLLECT: coeff_ready_out = output register empty or transferring.
    - Zero coefficient: run++. No record, unless it is index BLOCK_LEN-1, which loads EOB (symbol 0x00, amp_len 0, eob_out=1).
    - Nonzero coefficient with run<16: load symbol {run,size}, then run ← 0.
    - Nonzero coefficient with run≥16: latch it and go to EMIT_ZRL.
  - EMIT_ZRL: coeff_ready_out=0. Each output slot loads ZRL (symbol 0xF0, amp_len 0) and run −=16. When run<16, go to EMIT_SYM.
  - EMIT_SYM: load the latched symbol, run ← 0, return to COLLECT.
- Block end: index wraps BLOCK_LEN-1→0. If the final coefficient is nonzero, its symbol record carries eob_out=1 and no EOB record is emitted. Trailing zeros never produce ZRLs.
- Size category and amplitude:
  - Coefficient is first clamped to ±(2^(COEFF_WIDTH-1)-1); clamping sets err_out.
  - size = bit index of the magnitude MSB + 1.
  - amp = coeff if positive; otherwise (coeff−1) low size bits.
- Lookup: code and length come from the table latched at index 0, addressed by the symbol byte. Table read is combinational, result registered with the record. A length of 0 sets err_out; the record is still emitted.
- Table writes: accepted at any time, independent of the handshake. They affect lookups from the next cycle.
- Reset mid-block: pending ZRLs and the output record are discarded. The next accepted coefficient is index 0.
- err_out: clears only on reset.

Test Plan:
- Load the standard luma AC table into table 0. Block [5, 62×0] → (0,3): code 100 len 3, amp 101 len 3; then EOB: code 1010 len 4, eob_out=1.
- First coefficient −3 → code 01 len 2, amp 00 len 2. Coefficient −1023 → amp 0000000000 len 10, err_out stays 0. Coefficient −1024 → clamped, err_out=1.
- [20×0, 1, 42×0] → ZRL: 11111111001 len 11; then (4,1): 111011 len 6, amp 1 len 1; then EOB. coeff_ready_out=0 during the ZRL cycle.
- [62×0, 7] → 3 ZRLs, then (14,3) record with eob_out=1, no EOB record. All-zero block → exactly one EOB.
- Hold sym_ready_in low 5 cycles mid-block → outputs stable, coeff_ready_out=0, no record lost or duplicated. Back-to-back ready=1 → one record/cycle.
- Select table 1 (chroma) on the next block → chroma codes used. Assert rst_in after 10 coefficients → outputs 0, next coefficient is index 0, tables still intact.
